// File: rtl/cluster_rate_gen_pkg.sv
// Shared encodings and derived constants for the synthetic cluster-count generator.
package cluster_rate_gen_pkg;

  localparam int unsigned DEF_CLK_FREQUENCY = 40_000_000;
  localparam int unsigned DEF_MAX_PER_CLK   = 8;
  localparam int unsigned MAX_RATE          = DEF_MAX_PER_CLK * DEF_CLK_FREQUENCY;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_CONST = 2'd1,
    MODE_BURST = 2'd2,
    MODE_SHOT  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_BURST_ON,
    ST_BURST_GAP,
    ST_SHOT
  } state_e;

  function automatic logic [31:0] max_rate(int unsigned per_clk, int unsigned freq);
    return 32'(per_clk * freq);
  endfunction

  // Mode that keeps a state alive; any other mode_i value aborts to IDLE.
  function automatic mode_e state_mode(state_e st);
    case (st)
      ST_RUN:                    return MODE_CONST;
      ST_BURST_ON, ST_BURST_GAP: return MODE_BURST;
      ST_SHOT:                   return MODE_SHOT;
      default:                   return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/cluster_rate_gen_phase_acc.sv
// Phase accumulator: adds the clamped rate each step and peels off whole clusters
// with a constant comparator chain, keeping the fractional remainder.
module cluster_phase_acc
  import cluster_rate_gen_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = DEF_CLK_FREQUENCY,
  parameter int unsigned MAX_PER_CLK   = DEF_MAX_PER_CLK,
  parameter int unsigned COUNT_WIDTH   = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [31:0]            rate,
  input  logic                   step,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] n,
  output logic                   clamped
);

  localparam logic [31:0] F    = 32'(CLK_FREQUENCY);
  localparam logic [31:0] RMAX = max_rate(MAX_PER_CLK, CLK_FREQUENCY);

  logic [31:0] acc;
  logic [31:0] r;
  logic [31:0] s;
  logic [31:0] rem;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    clamped = (rate > RMAX);
    r       = clamped ? RMAX : rate;
    s       = acc + r;
    n       = '0;
    rem     = s;
    // Thresholds rise with k, so the last match is the largest whole count.
    for (int unsigned k = 1; k <= MAX_PER_CLK; k++) begin
      if (s >= 32'(k) * F) begin
        n   = COUNT_WIDTH'(k);
        rem = s - 32'(k) * F;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= rem;
    end
  end

endmodule

// File: rtl/cluster_rate_gen.sv
// Synthetic cluster_count source: constant, burst or single-shot emission at a
// programmable rate, with a saturating total of everything emitted.
module cluster_rate_gen
  import cluster_rate_gen_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY  = DEF_CLK_FREQUENCY,
  parameter int unsigned COUNT_WIDTH    = 8,
  parameter int unsigned MAX_PER_CLK    = DEF_MAX_PER_CLK,
  parameter int unsigned EMIT_CNT_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable_i,
  input  logic [1:0]                mode_i,
  input  logic [31:0]               rate_i,
  input  logic [15:0]               burst_len_i,
  input  logic [15:0]               burst_gap_i,
  input  logic                      fire_i,
  input  logic                      clear_i,
  output logic [COUNT_WIDTH-1:0]    cluster_count_o,
  output logic                      busy_o,
  output logic                      rate_clamped_o,
  output logic [EMIT_CNT_WIDTH-1:0] emitted_o
);

  state_e                   state_q, state_d;
  logic [15:0]              on_cnt_q, on_cnt_d;
  logic [15:0]              gap_cnt_q, gap_cnt_d;
  logic [COUNT_WIDTH-1:0]   count_d;
  logic                     acc_step, acc_clear;
  logic [COUNT_WIDTH-1:0]   acc_n;
  logic                     acc_clamped;
  logic [EMIT_CNT_WIDTH:0]  emit_sum;
  mode_e                    mode;

  assign mode     = mode_e'(mode_i);
  assign busy_o   = (state_q != ST_IDLE);
  assign emit_sum = {1'b0, emitted_o} + (EMIT_CNT_WIDTH + 1)'(cluster_count_o);

  cluster_phase_acc #(
    .CLK_FREQUENCY (CLK_FREQUENCY),
    .MAX_PER_CLK   (MAX_PER_CLK),
    .COUNT_WIDTH   (COUNT_WIDTH)
  ) u_phase_acc (
    .clock   (clock),
    .reset_n (reset_n),
    .rate    (rate_i),
    .step    (acc_step),
    .clear   (acc_clear),
    .n       (acc_n),
    .clamped (acc_clamped)
  );

  always_comb begin
    state_d   = state_q;
    on_cnt_d  = on_cnt_q;
    gap_cnt_d = gap_cnt_q;
    count_d   = '0;
    acc_step  = 1'b0;
    acc_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        acc_clear = 1'b1;
        if (enable_i) begin
          case (mode)
            MODE_CONST: state_d = ST_RUN;
            MODE_BURST: begin
              if (burst_len_i != 16'd0) begin
                state_d  = ST_BURST_ON;
                on_cnt_d = burst_len_i;
              end else begin
                state_d   = ST_BURST_GAP;
                gap_cnt_d = burst_gap_i;
              end
            end
            MODE_SHOT: begin
              if (fire_i) begin
                state_d = ST_SHOT;
                count_d = COUNT_WIDTH'(1);
              end
            end
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        acc_step = 1'b1;
        count_d  = acc_n;
      end

      ST_BURST_ON: begin
        acc_step = 1'b1;
        count_d  = acc_n;
        if (on_cnt_q <= 16'd1) begin
          // A zero gap reloads the on-time, giving continuous emission.
          if (burst_gap_i != 16'd0) begin
            state_d   = ST_BURST_GAP;
            gap_cnt_d = burst_gap_i;
          end else begin
            on_cnt_d = burst_len_i;
          end
        end else begin
          on_cnt_d = on_cnt_q - 16'd1;
        end
      end

      ST_BURST_GAP: begin
        // Accumulator is held, so the phase carries over into the next burst.
        if (gap_cnt_q <= 16'd1) begin
          if (burst_len_i != 16'd0) begin
            state_d  = ST_BURST_ON;
            on_cnt_d = burst_len_i;
          end else begin
            gap_cnt_d = burst_gap_i;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end

      ST_SHOT: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && (!enable_i || mode != state_mode(state_q))) begin
      state_d   = ST_IDLE;
      count_d   = '0;
      acc_step  = 1'b0;
      acc_clear = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      on_cnt_q        <= '0;
      gap_cnt_q       <= '0;
      cluster_count_o <= '0;
      rate_clamped_o  <= 1'b0;
      emitted_o       <= '0;
    end else begin
      state_q         <= state_d;
      on_cnt_q        <= on_cnt_d;
      gap_cnt_q       <= gap_cnt_d;
      cluster_count_o <= count_d;
      rate_clamped_o  <= acc_clamped;
      if (clear_i) begin
        emitted_o <= EMIT_CNT_WIDTH'(cluster_count_o);
      end else if (emit_sum[EMIT_CNT_WIDTH]) begin
        emitted_o <= '1;
      end else begin
        emitted_o <= emit_sum[EMIT_CNT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_cluster_rate_gen.sv
// Scoreboard bench for cluster_rate_gen: a cumulative-sum reference model queues
// expected outputs per clock and an independent monitor compares them.
module tb_cluster_rate_gen;

  localparam int unsigned     F    = 40_000_000;
  localparam int unsigned     PER  = 8;
  localparam int              EW   = 12;
  localparam longint unsigned RMAX = 64'(PER) * 64'(F);
  localparam longint unsigned EMAX = (64'd1 << EW) - 64'd1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable_i = 1'b0;
  logic [1:0]    mode_i = 2'd0;
  logic [31:0]   rate_i = 32'd0;
  logic [15:0]   burst_len_i = 16'd0;
  logic [15:0]   burst_gap_i = 16'd0;
  logic          fire_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [7:0]    cluster_count_o;
  logic          busy_o;
  logic          rate_clamped_o;
  logic [EW-1:0] emitted_o;

  cluster_rate_gen #(
    .CLK_FREQUENCY  (F),
    .COUNT_WIDTH    (8),
    .MAX_PER_CLK    (PER),
    .EMIT_CNT_WIDTH (EW)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable_i        (enable_i),
    .mode_i          (mode_i),
    .rate_i          (rate_i),
    .burst_len_i     (burst_len_i),
    .burst_gap_i     (burst_gap_i),
    .fire_i          (fire_i),
    .clear_i         (clear_i),
    .cluster_count_o (cluster_count_o),
    .busy_o          (busy_o),
    .rate_clamped_o  (rate_clamped_o),
    .emitted_o       (emitted_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    longint unsigned count;
    bit              busy;
    bit              clamp;
    longint unsigned emitted;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: emission is the growth of floor(sum_of_rates / F) over active steps.
  bit              m_active;
  int unsigned     m_amode;
  longint unsigned m_t;
  longint unsigned m_cum;
  longint unsigned m_count;
  longint unsigned m_emitted;
  bit              m_clamp;

  task automatic model_reset();
    m_active  = 1'b0;
    m_amode   = 0;
    m_t       = 0;
    m_cum     = 0;
    m_count   = 0;
    m_emitted = 0;
    m_clamp   = 1'b0;
  endtask

  task automatic model_step();
    longint unsigned r, old_cum, len, gap;
    bit on;
    if (clear_i) m_emitted = m_count;
    else         m_emitted = (m_emitted + m_count > EMAX) ? EMAX : m_emitted + m_count;
    m_clamp = (64'(rate_i) > RMAX);
    r = m_clamp ? RMAX : 64'(rate_i);
    if (!m_active) begin
      m_count = 0;
      m_cum   = 0;
      m_t     = 0;
      if (enable_i && mode_i == 2'd1) begin
        m_active = 1'b1; m_amode = 1;
      end else if (enable_i && mode_i == 2'd2) begin
        m_active = 1'b1; m_amode = 2;
      end else if (enable_i && mode_i == 2'd3 && fire_i) begin
        m_active = 1'b1; m_amode = 3; m_count = 1;
      end
    end else if (!enable_i || int'(mode_i) != int'(m_amode) || m_amode == 3) begin
      m_active = 1'b0;
      m_count  = 0;
      m_cum    = 0;
    end else begin
      len = 64'(burst_len_i);
      gap = 64'(burst_gap_i);
      on  = (m_amode == 1) || (len != 0 && (m_t % (len + gap)) < len);
      if (on) begin
        old_cum = m_cum;
        m_cum   = m_cum + r;
        m_count = m_cum / F - old_cum / F;
      end else begin
        m_count = 0;
      end
      m_t++;
    end
    exp_q.push_back('{m_count, m_active, m_clamp, m_emitted});
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    model_step();
    @(negedge clock);
  endtask

  function automatic logic [31:0] pick_rate();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 200_000));
      1:       return 32'(F);
      2:       return 32'($urandom_range(F, 320_000_000));
      3:       return $urandom;
      4:       return ($urandom_range(0, 1) == 0) ? 32'(RMAX) : 32'(RMAX + 1);
      default: return 32'($urandom_range(1_000_000, 60_000_000));
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_count",   64'(cluster_count_o), e.count);
        check("sb_busy",    64'(busy_o),          64'(e.busy));
        check("sb_clamp",   64'(rate_clamped_o),  64'(e.clamp));
        check("sb_emitted", 64'(emitted_o),       e.emitted);
      end
    end
  end

  initial begin : stimulus
    int pat[8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    int pulse_pos[$];
    int non_one;
    bit found;

    repeat (2) @(negedge clock);
    check("reset_count",   64'(cluster_count_o), 64'd0);
    check("reset_busy",    64'(busy_o),          64'd0);
    check("reset_clamp",   64'(rate_clamped_o),  64'd0);
    check("reset_emitted", 64'(emitted_o),       64'd0);
    reset_n = 1'b1;
    model_reset();

    // Constant 20 kHz: one cluster every 2000 clocks.
    mode_i = 2'd1; rate_i = 32'd20_000; enable_i = 1'b1;
    tick();
    non_one = 0;
    for (int i = 1; i <= 40_000; i++) begin
      tick();
      if (cluster_count_o != 8'd0) begin
        pulse_pos.push_back(i);
        if (cluster_count_o != 8'd1) non_one++;
      end
    end
    check("const_pulse_total", 64'(pulse_pos.size()), 64'd20);
    check("const_pulse_value", 64'(non_one), 64'd0);
    if (pulse_pos.size() > 0) check("const_first_pulse", 64'(pulse_pos[0]), 64'd2000);
    for (int i = 1; i < pulse_pos.size(); i++)
      check("const_pulse_spacing", 64'(pulse_pos[i] - pulse_pos[i-1]), 64'd2000);
    tick();
    check("const_emitted", 64'(emitted_o), 64'd20);
    enable_i = 1'b0;
    tick();

    // Two clusters per clock, not clamped.
    rate_i = 32'd80_000_000; enable_i = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("double_count", 64'(cluster_count_o), 64'd2);
      check("double_clamp", 64'(rate_clamped_o),  64'd0);
    end
    enable_i = 1'b0;
    tick();

    // Over-range rate: clamped to eight per clock; long enough to saturate emitted_o.
    rate_i = 32'd400_000_000; enable_i = 1'b1;
    tick();
    for (int i = 0; i < 600; i++) tick();
    check("clamp_count",   64'(cluster_count_o), 64'd8);
    check("clamp_flag",    64'(rate_clamped_o),  64'd1);
    check("emitted_sat",   64'(emitted_o),       EMAX);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("emitted_clear", 64'(emitted_o), 64'd8);
    enable_i = 1'b0;
    tick();

    // Burst 3 on / 5 off at one cluster per clock.
    mode_i = 2'd2; rate_i = 32'(F); burst_len_i = 16'd3; burst_gap_i = 16'd5; enable_i = 1'b1;
    tick();
    check("burst_busy_entry", 64'(busy_o), 64'd1);
    for (int k = 2; k <= 25; k++) begin
      tick();
      check("burst_pattern", 64'(cluster_count_o), 64'(pat[(k-2) % 8]));
      check("burst_busy",    64'(busy_o),          64'd1);
    end

    // Reset while a cluster is on the output, then restart with enable held.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (cluster_count_o == 8'd1) found = 1'b1;
    end
    check("burst_found_on", 64'(found), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_count",   64'(cluster_count_o), 64'd0);
    check("async_reset_busy",    64'(busy_o),          64'd0);
    check("async_reset_emitted", 64'(emitted_o),       64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    tick();
    for (int k = 2; k <= 9; k++) begin
      tick();
      check("restart_pattern", 64'(cluster_count_o), 64'(pat[(k-2) % 8]));
    end
    enable_i = 1'b0;
    tick();

    // Single shot: fire held two clocks yields exactly one cluster.
    mode_i = 2'd3; enable_i = 1'b1; clear_i = 1'b1;
    tick();
    clear_i = 1'b0; fire_i = 1'b1;
    tick();
    check("shot_count", 64'(cluster_count_o), 64'd1);
    check("shot_busy",  64'(busy_o),          64'd1);
    tick();
    fire_i = 1'b0;
    check("shot_done_count", 64'(cluster_count_o), 64'd0);
    check("shot_done_busy",  64'(busy_o),          64'd0);
    tick();
    check("shot_emitted", 64'(emitted_o), 64'd1);

    // Randomized segments: mode, rate, burst shape, fire, clear, enable and mode changes.
    for (int s = 0; s < 40; s++) begin
      enable_i = 1'b0; clear_i = 1'b0; fire_i = 1'b0;
      tick();
      mode_i      = 2'($urandom_range(0, 3));
      burst_len_i = 16'($urandom_range(0, 6));
      burst_gap_i = 16'($urandom_range(0, 6));
      rate_i      = pick_rate();
      enable_i    = 1'b1;
      for (int c = 0; c < int'($urandom_range(20, 120)); c++) begin
        if ($urandom_range(0, 15) == 0) rate_i = pick_rate();
        if ($urandom_range(0, 31) == 0) mode_i = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 31) == 0) enable_i = ~enable_i;
        fire_i  = ($urandom_range(0, 3) == 0);
        clear_i = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    enable_i = 1'b0; fire_i = 1'b0; clear_i = 1'b0;
    tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cluster_rate_gen.md
Name: cluster_rate_gen

Overview:
- Synthetic cluster-count source that drives an 8-bit per-clock cluster_count into the rate counter and LED progress-bar logic.
- Used for bench and in-system checks of the rate display and cylon trigger without real trigger data.
- Sits in src/utils. Its output is muxed onto the cluster_count input of the LED controller under a slow-control enable.
- Emission is a phase accumulator at a programmable rate, in constant, burst or single-shot mode.

Parameters:
CLK_FREQUENCY, 40000000, clock frequency in Hz; also the accumulator modulus F
COUNT_WIDTH, 8, width of cluster_count_o
MAX_PER_CLK, 8, maximum clusters emitted in one clock; rate_i is clamped to MAX_PER_CLK*F
EMIT_CNT_WIDTH, 32, width of the emitted-cluster total counter

Ports:
clock  in  1  system 40 MHz clock
reset_n  in  1  asynchronous active-low reset
enable_i  in  1  generator enable; low forces IDLE
mode_i  in  2  0=off, 1=constant, 2=burst, 3=single-shot
rate_i  in  32  target rate in clusters per second
burst_len_i  in  16  burst on-time in clocks
burst_gap_i  in  16  burst off-time in clocks
fire_i  in  1  single-shot trigger pulse
clear_i  in  1  synchronous clear of emitted_o
cluster_count_o  out  COUNT_WIDTH  clusters this clock (registered)
busy_o  out  1  high in any state except IDLE
rate_clamped_o  out  1  rate_i exceeds MAX_PER_CLK*F
emitted_o  out  EMIT_CNT_WIDTH  saturating total of cluster_count_o

Behaviour:
- Reset (async assert, sync release): all outputs 0; acc=0; state=IDLE; burst counters=0.
- Rate path:
  - r = min(rate_i, MAX_PER_CLK*F). rate_clamped_o is registered from (rate_i > MAX_PER_CLK*F).
  - s = acc + r, computed in 32 bits; s < (MAX_PER_CLK+1)*F, so it cannot overflow.
  - n = largest k in 0..MAX_PER_CLK with s >= k*F. Implement as a comparator chain against constants; no divider.
  - When accumulating: acc <= s - n*F, and cluster_count_o <= n at the next edge. Latency from rate_i change to output is 1 clock.
- States:
  - IDLE:
    - cluster_count_o=0; acc held at 0.
    - If enable_i: mode 1 -> RUN.
    - mode 2 -> BURST_ON, with on_cnt=burst_len_i. If burst_len_i==0, go to BURST_GAP instead.
    - mode 3 with fire_i -> SHOT.
  - RUN: accumulate every clock.
  - BURST_ON:
    - Accumulate; on_cnt decrements each clock.
    - When on_cnt reaches 1 -> BURST_GAP with gap_cnt=burst_gap_i. If burst_gap_i==0, reload BURST_ON instead, giving continuous emission.
  - BURST_GAP:
    - Output 0; acc held, so the phase is continuous across bursts.
    - When gap_cnt reaches 1 -> BURST_ON, reloading burst_len_i. If burst_len_i==0, stay in GAP.
  - SHOT: cluster_count_o=1 for exactly one clock, then -> IDLE. fire_i during SHOT is ignored.
- From any state, enable_i low or a change of mode_i -> IDLE next clock; acc cleared; output 0 that clock.
- Burst lengths and gaps are sampled only at reload; mid-burst changes take effect at the next reload.
- emitted_o:
  - Adds cluster_count_o each clock and saturates at all-ones without wrapping.
  - When clear_i is high, clear wins: emitted_o <= that clock's emission value.
- Reset mid-burst: output 0 immediately (async). Restart follows the IDLE rules.

Decomposition:
- Shared package holds the mode encodings (MODE_OFF/CONST/BURST/SHOT) and the state enum.
- It also holds the derived constant MAX_RATE = MAX_PER_CLK*CLK_FREQUENCY.
- One sub-module, cluster_phase_acc: the accumulator plus comparator chain. Inputs are r, step enable and clear; outputs are n and the clamp flag.

Test Plan:
- mode=1, rate_i=20000, 40000 clocks -> exactly 20 single-cluster pulses spaced 2000 clocks apart; emitted_o=20.
- mode=1, rate_i=80000000 -> cluster_count_o=2 every clock from the 2nd clock; rate_clamped_o=0.
- mode=1, rate_i=400000000 -> cluster_count_o=8 every clock; rate_clamped_o=1.
- mode=2, rate_i=40000000, len=3, gap=5 -> repeating pattern 1,1,1,0,0,0,0,0; busy_o=1 throughout.
- mode=3, fire_i pulsed twice 1 clock apart -> a single 1-clock output of 1; busy_o high 1 clock; emitted_o=1.
- mode=2, reset_n low mid-burst then high -> outputs 0 asynchronously; IDLE; with enable held, a fresh burst of full len_i restarts 1 clock after release.
